// File: rtl/run_ctl.sv
// Processor run-control sequencer: turns front-panel run/stop, single-step and an
// address breakpoint into a registered one-cycle clock-enable pulse stream.
module run_ctl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sel,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      addr,
    output logic             cpu_en,
    output logic             running,
    output logic             bp_halt,
    output logic [CNT_W-1:0] en_cnt
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } state_t;

    // Terminal prescaler value (divisor minus one) for each rate select.
    function automatic logic [19:0] div_last(input logic [2:0] s);
        logic [19:0] r;
        case (s)
            3'd0:    r = 20'd0;
            3'd1:    r = 20'd9;
            3'd2:    r = 20'd999;
            3'd3:    r = 20'd9999;
            3'd4:    r = 20'd99999;
            3'd5:    r = 20'd999999;
            3'd6:    r = 20'd1;
            default: r = 20'd0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic             run_prev_q, step_prev_q;
    logic [2:0]       sel_q;
    logic [19:0]      presc_q, presc_d;
    logic             skip_q, skip_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q, bp_halt_q;
    logic [CNT_W-1:0] en_cnt_q;

    logic run_rise_s, step_rise_s, sel_chg_s, no_tick_s, tick_s, hit_s;

    assign run_rise_s  = run_btn & ~run_prev_q;
    assign step_rise_s = step_btn & ~step_prev_q;
    assign sel_chg_s   = (sel != sel_q);
    assign no_tick_s   = (sel == 3'd7);
    assign tick_s      = ~sel_chg_s & ~no_tick_s & (presc_q == div_last(sel));
    assign hit_s       = (state_q == ST_RUN) & tick_s & bp_en & (addr == bp_addr) & ~skip_q;

    // Prescaler next value: a rate change restarts the count without a tick.
    always_comb begin
        presc_d = presc_q + 20'd1;
        if (sel_chg_s || no_tick_s || tick_s) begin
            presc_d = 20'd0;
        end else begin
            presc_d = presc_q + 20'd1;
        end
    end

    // Run-state transitions, enable pulse and breakpoint-skip bookkeeping.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        skip_d   = skip_q;
        case (state_q)
            ST_STOP: begin
                if (run_rise_s) begin
                    state_d = ST_RUN;
                end else if (step_rise_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_RUN: begin
                cpu_en_d = tick_s & ~hit_s;
                if (run_rise_s) begin
                    state_d = ST_STOP;
                end else if (hit_s) begin
                    state_d = ST_BRK;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en_d = 1'b1;
                state_d  = ST_STOP;
            end
            ST_BRK: begin
                if (run_rise_s) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (step_rise_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
        // Resume skip is spent by the first issued pulse, or dropped on stopping.
        if (cpu_en_d || (state_d == ST_STOP)) begin
            skip_d = 1'b0;
        end else begin
            skip_d = skip_d;
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_STOP;
            run_prev_q  <= 1'b1;
            step_prev_q <= 1'b1;
            sel_q       <= sel;
            presc_q     <= 20'd0;
            skip_q      <= 1'b0;
            cpu_en_q    <= 1'b0;
            running_q   <= 1'b0;
            bp_halt_q   <= 1'b0;
            en_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            run_prev_q  <= run_btn;
            step_prev_q <= step_btn;
            sel_q       <= sel;
            presc_q     <= presc_d;
            skip_q      <= skip_d;
            cpu_en_q    <= cpu_en_d;
            running_q   <= (state_d == ST_RUN);
            bp_halt_q   <= (state_d == ST_BRK);
            en_cnt_q    <= en_cnt_q + {{(CNT_W-1){1'b0}}, cpu_en_q};
        end
    end

    assign cpu_en  = cpu_en_q;
    assign running = running_q;
    assign bp_halt = bp_halt_q;
    assign en_cnt  = en_cnt_q;

endmodule

// File: tb/tb_run_ctl.sv
// Bench for run_ctl: directed panel scenarios plus random stimulus, every cycle
// compared against a rule-level reference model of the sequencer.
module tb_run_ctl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       sel;
    logic             run_btn, step_btn, bp_en;
    logic [31:0]      bp_addr, addr;
    logic             cpu_en, running, bp_halt;
    logic [CNT_W-1:0] en_cnt;

    int n_err = 0;
    int n_chk = 0;
    int obs   = 0;

    // Reference model state: mode 0=stopped, 1=running, 2=stepping, 3=halted at breakpoint.
    int  m_mode, m_phase, m_cnt;
    int  m_selq;
    bit  m_runp, m_stepp, m_skip, m_en;
    int  divs [8];

    run_ctl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sel(sel), .run_btn(run_btn), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .addr(addr), .cpu_en(cpu_en),
        .running(running), .bp_halt(bp_halt), .en_cnt(en_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_cnt = 0; m_selq = int'(sel);
        m_runp = 1'b1; m_stepp = 1'b1; m_skip = 1'b0; m_en = 1'b0;
    endtask

    // Applies the sequencer rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit rr, sr, tick, hit, new_en;
        int d, nxt;
        if (reset) begin
            model_reset();
            return;
        end
        rr = run_btn && !m_runp;
        sr = step_btn && !m_stepp;
        d  = divs[sel];
        tick = (int'(sel) == m_selq) && (d != 0) && (m_phase == d - 1);
        m_phase = (int'(sel) != m_selq || d == 0 || tick) ? 0 : m_phase + 1;
        hit = (m_mode == 1) && tick && bp_en && (addr == bp_addr) && !m_skip;
        new_en = ((m_mode == 1) && tick && !hit) || (m_mode == 2);
        m_cnt = (m_cnt + int'(m_en)) % (1 << CNT_W);
        nxt = m_mode;
        case (m_mode)
            0: nxt = rr ? 1 : (sr ? 2 : 0);
            1: nxt = rr ? 0 : (hit ? 3 : 1);
            2: nxt = 0;
            default: begin
                nxt = rr ? 1 : (sr ? 2 : 3);
                if (rr) m_skip = 1'b1;
            end
        endcase
        if (new_en || nxt == 0) m_skip = 1'b0;
        m_mode = nxt;
        m_en = new_en;
        m_runp = run_btn; m_stepp = step_btn; m_selq = int'(sel);
    endtask

    // One clock: update the model at the edge, compare just after it, and let the
    // modelled processor advance its fetch address on each enable.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("cpu_en", cpu_en, m_en);
            check("running", running, m_mode == 1);
            check("bp_halt", bp_halt, m_mode == 3);
            check("en_cnt", en_cnt, m_cnt);
            if (cpu_en) obs++;
            if (m_en) addr = addr + 32'd1;
        end
    endtask

    initial begin
        divs = '{1, 10, 1000, 10000, 100000, 1000000, 2, 0};
        reset = 1'b1; sel = 3'd3; run_btn = 1'b0; step_btn = 1'b0;
        bp_en = 1'b0; bp_addr = 32'd0; addr = 32'd0;
        model_reset();
        cycles(3);
        reset = 1'b0;
        cycles(2);

        // Long single-step press yields exactly one pulse.
        obs = 0; step_btn = 1'b1;
        cycles(50);
        check("step_pulses", obs, 1);
        check("step_cnt", en_cnt, 1);
        check("step_stopped", running, 0);
        step_btn = 1'b0;
        cycles(2);

        // Run at divide-by-10 for ~100 cycles, then stop.
        sel = 3'd1; cycles(1);
        obs = 0; run_btn = 1'b1;
        cycles(100);
        check("run_running", running, 1);
        run_btn = 1'b0; cycles(1);
        run_btn = 1'b1; cycles(20);
        check("run_pulse_range", (obs >= 9 && obs <= 11), 1);
        check("run_stopped", running, 0);

        // Breakpoint at 0x10 with full-rate running from address 0.
        run_btn = 1'b0; sel = 3'd0; bp_en = 1'b1; bp_addr = 32'h10; addr = 32'd0;
        cycles(2);
        obs = 0; run_btn = 1'b1;
        cycles(30);
        check("bp_pulses", obs, 16);
        check("bp_halt_set", bp_halt, 1);
        check("bp_addr_hold", addr, 32'h10);
        run_btn = 1'b0; cycles(1);
        run_btn = 1'b1; cycles(4);
        check("bp_resume_run", running, 1);
        check("bp_resume_past", (addr > 32'h10), 1);
        addr = 32'h0C;
        cycles(10);
        check("bp_rehalt", bp_halt, 1);
        check("bp_rehalt_addr", addr, 32'h10);

        // Simultaneous run and step rises from STOP: run only, no step pulse.
        reset = 1'b1; run_btn = 1'b0; cycles(2);
        reset = 1'b0; bp_en = 1'b0; sel = 3'd7; cycles(2);
        obs = 0; run_btn = 1'b1; step_btn = 1'b1;
        cycles(5);
        check("both_running", running, 1);
        check("both_no_pulse", obs, 0);

        // Rate change mid-count restarts the prescaler.
        step_btn = 1'b0; sel = 3'd2;
        cycles(500);
        sel = 3'd1; obs = 0;
        cycles(10);
        check("selchg_none_yet", obs, 0);
        cycles(1);
        check("selchg_first", obs, 1);
        sel = 3'd7; obs = 0;
        cycles(50);
        check("sel7_no_pulse", obs, 0);
        check("sel7_running", running, 1);

        // Enable counter wrap, then reset while running.
        reset = 1'b1; run_btn = 1'b0; cycles(2);
        reset = 1'b0; sel = 3'd0; cycles(1);
        run_btn = 1'b1; cycles(1);
        cycles(16);
        check("cnt_15", en_cnt, 15);
        cycles(1);
        check("cnt_wrap", en_cnt, 0);
        reset = 1'b1; cycles(1);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_running", running, 0);
        check("rst_cnt", en_cnt, 0);
        reset = 1'b0;

        // Randomized panel activity.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39, 0) == 0) sel = 3'($urandom_range(7, 0) > 4 ? $urandom_range(7, 6) : $urandom_range(2, 0));
            if ($urandom_range(24, 0) == 0) run_btn = ~run_btn;
            if ($urandom_range(19, 0) == 0) step_btn = ~step_btn;
            if ($urandom_range(49, 0) == 0) bp_en = ($urandom_range(3, 0) != 0);
            if ($urandom_range(59, 0) == 0) bp_addr = addr + 32'($urandom_range(12, 0));
            if ($urandom_range(99, 0) == 0) addr = 32'($urandom_range(31, 0));
            reset = ($urandom_range(399, 0) == 0);
            cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
